// File: rtl/i2c_target_regbank.sv
// I2C target with a 16-bit-addressed byte register bank, fabric write strobes and a side read port.
// Pad inputs are synchronized and debounced; all protocol decisions use the filtered levels.
module i2c_target_regbank #(
  parameter logic [6:0]  DEV_ADDR = 7'h54,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned FILT     = 3
) (
  input  logic                     FPGA_Clock,
  input  logic                     FPGA_RST_n,
  input  logic                     scl_in,
  input  logic                     sda_in,
  output logic                     sda_oe,
  output logic                     busy,
  output logic                     wr_valid,
  output logic [15:0]              wr_addr,
  output logic [7:0]               wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_data
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(FILT + 1);

  typedef enum logic [2:0] {IDLE, ADDR, ACK_A, RA_H, RA_L, WR, RD, IGNORE} state_t;

  // index 0 = SCL, index 1 = SDA
  logic [1:0]    w_pad, r_sync1, r_sync2, r_filt, r_filt_d;
  logic [CW-1:0] r_cnt [2];

  assign w_pad = {sda_in, scl_in};

  always_ff @(posedge FPGA_Clock or negedge FPGA_RST_n) begin
    if (!FPGA_RST_n) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_filt   <= '1;
      r_filt_d <= '1;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_sync1  <= w_pad;
      r_sync2  <= r_sync1;
      r_filt_d <= r_filt;
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(FILT - 1)) begin
          r_filt[i] <= r_sync2[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_sda      = r_filt[1];
  assign w_scl_rise = r_filt[0] & ~r_filt_d[0];
  assign w_scl_fall = ~r_filt[0] & r_filt_d[0];
  assign w_start    = r_filt[0] & r_filt_d[0] & ~r_filt[1] & r_filt_d[1];
  assign w_stop     = r_filt[0] & r_filt_d[0] & r_filt[1] & ~r_filt_d[1];

  state_t      r_state, w_state_n;
  logic [3:0]  r_bitcnt, w_bitcnt_n;
  logic [7:0]  r_shift, w_shift_n;
  logic [15:0] r_ptr, w_ptr_n;
  logic        r_sda_oe, w_sda_oe_n;
  logic        r_busy, w_busy_n;
  logic        w_wr_stb, w_bank_we;
  logic        r_wr_valid;
  logic [15:0] r_wr_addr;
  logic [7:0]  r_wr_data, r_rd_data;
  logic [7:0]  r_bank [DEPTH];
  logic [15:0] w_load_ptr;
  logic [7:0]  w_load_byte;

  // In RD the next byte is fetched for the already-incremented pointer.
  assign w_load_ptr  = (r_state == RD) ? r_ptr + 16'd1 : r_ptr;
  assign w_load_byte = (w_load_ptr < 16'(DEPTH)) ? r_bank[w_load_ptr[AW-1:0]] : '0;
  assign w_bank_we   = w_wr_stb && (r_ptr < 16'(DEPTH));

  // bitcnt counts SCL rises in the byte: 8 = ACK clock pending, 9 = ACK clock high.
  always_comb begin
    w_state_n  = r_state;
    w_bitcnt_n = r_bitcnt;
    w_shift_n  = r_shift;
    w_ptr_n    = r_ptr;
    w_sda_oe_n = r_sda_oe;
    w_busy_n   = r_busy;
    w_wr_stb   = 1'b0;
    if (w_stop) begin
      w_state_n  = IDLE;
      w_sda_oe_n = 1'b0;
      w_busy_n   = 1'b0;
    end else if (w_start) begin
      w_state_n  = ADDR;
      w_bitcnt_n = '0;
      w_sda_oe_n = 1'b0;
    end else if (r_state != IDLE && r_state != IGNORE) begin
      if (w_scl_rise) begin
        // RD also shifts, so shift[7] is the next bit to drive and shift[0] ends up as the ACK bit.
        if (r_bitcnt < 4'd8 || r_state == RD) w_shift_n = {r_shift[6:0], w_sda};
        if (r_bitcnt < 4'd9) w_bitcnt_n = r_bitcnt + 4'd1;
      end else if (w_scl_fall) begin
        case (r_state)
          ADDR: if (r_bitcnt == 4'd8) begin
            if (r_shift[7:1] == DEV_ADDR) begin
              w_state_n  = ACK_A;
              w_busy_n   = 1'b1;
              w_sda_oe_n = 1'b1;
            end else begin
              w_state_n = IGNORE;
            end
          end
          ACK_A: if (r_bitcnt == 4'd9) begin
            w_bitcnt_n = '0;
            if (r_shift[0]) begin
              w_state_n  = RD;
              w_shift_n  = w_load_byte;
              w_sda_oe_n = ~w_load_byte[7];
            end else begin
              w_state_n  = RA_H;
              w_sda_oe_n = 1'b0;
            end
          end
          RA_H, RA_L, WR: begin
            if (r_bitcnt == 4'd8) begin
              w_sda_oe_n = 1'b1;
            end else if (r_bitcnt == 4'd9) begin
              w_sda_oe_n = 1'b0;
              w_bitcnt_n = '0;
              if (r_state == RA_H) begin
                w_ptr_n[15:8] = r_shift;
                w_state_n     = RA_L;
              end else if (r_state == RA_L) begin
                w_ptr_n[7:0] = r_shift;
                w_state_n    = WR;
              end else begin
                w_wr_stb = 1'b1;
                w_ptr_n  = r_ptr + 16'd1;
              end
            end
          end
          RD: begin
            if (r_bitcnt == 4'd9) begin
              w_ptr_n    = r_ptr + 16'd1;
              w_bitcnt_n = '0;
              if (!r_shift[0]) begin
                w_shift_n  = w_load_byte;
                w_sda_oe_n = ~w_load_byte[7];
              end else begin
                w_state_n  = IGNORE;
                w_sda_oe_n = 1'b0;
              end
            end else if (r_bitcnt == 4'd8) begin
              w_sda_oe_n = 1'b0;
            end else if (r_bitcnt != 4'd0) begin
              w_sda_oe_n = ~r_shift[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge FPGA_Clock or negedge FPGA_RST_n) begin
    if (!FPGA_RST_n) begin
      r_state    <= IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_ptr      <= '0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_state    <= w_state_n;
      r_bitcnt   <= w_bitcnt_n;
      r_shift    <= w_shift_n;
      r_ptr      <= w_ptr_n;
      r_sda_oe   <= w_sda_oe_n;
      r_busy     <= w_busy_n;
      r_wr_valid <= w_wr_stb;
      if (w_wr_stb) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= r_shift;
      end
    end
  end

  always_ff @(posedge FPGA_Clock or negedge FPGA_RST_n) begin
    if (!FPGA_RST_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_bank[i] <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_bank_we) r_bank[r_ptr[AW-1:0]] <= r_shift;
      r_rd_data <= r_bank[rd_addr];
    end
  end

  assign sda_oe   = r_sda_oe;
  assign busy     = r_busy;
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign rd_data  = r_rd_data;
endmodule

// File: doc/i2c_target_regbank.md
Name: i2c_target_regbank

Overview:
I2C target (responder) with a 16-bit-addressed byte register bank, used on board as a stand-in for the camera sensor's configuration port. It lets the Nios V I2C initiator path be exercised without a sensor fitted. Sits on the open-drain SCL/SDA pad pair; the top level converts sda_oe to a 0/Z driver. Fabric logic sees one-cycle write strobes and has a side read port into the bank.

Parameters:
DEV_ADDR, 7'h54, 7-bit target address this block responds to
DEPTH, 256, number of implemented registers (power of 2, 16..1024), at indices 0..DEPTH-1
FILT, 3, number of consecutive equal synchronized samples needed to accept an SCL/SDA level change

Ports:
FPGA_Clock  input  1  system clock, 25 MHz
FPGA_RST_n  input  1  asynchronous active-low reset
scl_in  input  1  SCL pad level (asynchronous)
sda_in  input  1  SDA pad level (asynchronous)
sda_oe  output  1  1 = pull SDA low; 0 = release
busy  output  1  high from an accepted address match until STOP
wr_valid  output  1  one-cycle pulse per byte written into the bank
wr_addr  output  16  register address of the write flagged by wr_valid
wr_data  output  8  data of the write flagged by wr_valid
rd_addr  input  $clog2(DEPTH)  fabric read index
rd_data  output  8  bank[rd_addr], registered, 1-cycle latency

Behaviour:
- Clock and reset: one clock, FPGA_Clock. Reset FPGA_RST_n is asynchronous, active-low.
- Reset values: sda_oe=0, busy=0, wr_valid=0, wr_addr=0, wr_data=0, rd_data=0. The bank clears to 0x00. The pointer is 0. The state is IDLE. The filtered SCL and SDA levels are 1.
- Input conditioning: 2-flop synchronizer on each input, then a FILT-sample majority-free debounce. The filtered level changes only after FILT identical samples. Edge and condition detection runs on the filtered levels.
- START: filtered SDA falls while SCL=1. STOP: filtered SDA rises while SCL=1. Both are recognized in any state.
  - STOP: go to IDLE, sda_oe=0, busy=0.
  - START (including repeated START): go to ADDR, bit counter = 0.
- Data sampling and driving:
  - Data bits are sampled on the filtered SCL rising edge.
  - sda_oe changes only on the filtered SCL falling edge, at the cycle the edge is detected.
  - No clock stretching.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first.
    - Bits [7:1] == DEV_ADDR: go to ACK_A and set busy=1.
    - Otherwise: go to IGNORE, no ACK, sda_oe stays 0 until STOP or START.
  - ACK_A: drive ACK (sda_oe=1) for the 9th clock. Then:
    - R/W=0: go to RA_H.
    - R/W=1: go to RD and preload the shift register with bank[pointer].
  - RA_H, then ACK: shift in pointer[15:8].
  - RA_L, then ACK: shift in pointer[7:0].
  - WR: each received byte is ACKed.
    - If pointer < DEPTH: write bank[pointer].
    - At the falling edge ending the ACK: wr_valid=1 for one cycle, with wr_addr = pointer and wr_data = byte. This pulse occurs for all pointer values, including pointer >= DEPTH.
    - Then pointer increments.
  - RD: drive the byte MSB first (sda_oe = ~bit). Release at the 9th clock and sample the initiator's ACK/NACK.
    - ACK: pointer increments and the next byte loads.
    - NACK: go to IGNORE, with the pointer already incremented past the last byte sent.
  - A read of pointer >= DEPTH returns 0x00.
- Pointer arithmetic: 16-bit, wraps 0xFFFF -> 0x0000. The bank index is pointer[$clog2(DEPTH)-1:0], used only when pointer < DEPTH.
- Pointer persistence: the pointer survives STOP and START, so a read without an address phase continues from the last pointer. It is cleared only by reset.
- Write with an address phase only (START, addr+W, RA_H, RA_L, STOP): sets the pointer, no bank write, no wr_valid.
- STOP or START mid-byte: discard the partial byte. No write, no wr_valid, pointer unchanged. A partially received RA_H/RA_L byte leaves the pointer unchanged; a completed RA_H byte updates pointer[15:8] only.
- Side read port: rd_data updates every cycle. When rd_addr equals the index being written in the same cycle, rd_data returns the old value.
- Reset mid-transaction: all outputs return to reset values immediately. sda_oe=0 releases the bus.

Test Plan:
- Write burst: START, 0xA8, 0x00, 0x10, 0x5A, 0xC3, STOP -> ACK on all 5 bytes; wr_valid pulses (0x0010,0x5A) then (0x0011,0xC3); rd_addr=0x10/0x11 give 0x5A/0xC3.
- Random read: START, 0xA8, 0x00, 0x10, repeated START, 0xA9, read 2 bytes (ACK then NACK), STOP -> SDA carries 0x5A, 0xC3; next current-address read returns bank[0x12]=0x00.
- Wrong address: START, 0xAA, data -> SDA never driven, busy=0, no wr_valid.
- Out of range / wrap: pointer 0xFFFF, write 0x11, 0x22 -> both ACKed; wr_valid addresses 0xFFFF then 0x0000; bank[0x00]=0x22; bank at index 0xFF unchanged.
- Glitches and aborts:
  - FILT-1-cycle pulses on SCL and SDA during a write -> ignored, byte still correct.
  - STOP after 4 data bits -> no wr_valid, pointer unchanged.
- Reset asserted while driving a read 0 bit -> sda_oe=0 in the same cycle; the bank reads back 0x00.
